// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display scanner with frame-coherent input snapshot and anti-ghost blanking.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits at each frame snapshot.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned IW        = $clog2(NUM_DIGITS)
) (
  input  logic                    clock_in,
  input  logic                    rst,
  input  logic                    refresh_in,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [IW-1:0]           digit_idx
);

  typedef enum logic {IDLE, BLANK} phase_t;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [IW-1:0]         IDX_TOP = IW'(NUM_DIGITS - 1);

  phase_t phase_q, phase_d;

  logic sync1_q, sync2_q, edge_q;
  logic tick;
  logic wrap;

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [NUM_DIGITS-1:0]   sel;
  logic [IW-1:0]           idx_d;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] v,
                                           input logic [IW-1:0] i);
    logic [3:0] n;
    n = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == i) n = v[4*k +: 4];
    end
    return n;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; blanking stops at the first non-zero nibble or set dp.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v,
                                                    input logic [NUM_DIGITS-1:0]   d,
                                                    input logic [NUM_DIGITS-1:0]   e);
    logic [NUM_DIGITS-1:0] m;
    logic                  leading;
    m       = e;
    leading = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && (v[4*k +: 4] == 4'h0) && !d[k]) m[k] = 1'b0;
      else leading = 1'b0;
    end
    return m;
  endfunction
`endif

  assign tick = sync2_q & ~edge_q;
  assign wrap = (digit_idx == IDX_TOP);

  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      sel[k] = (IW'(k) == digit_idx);
    end
  end

  // Digit 0 of a new frame decodes from the just-captured snapshot, not the old shadow.
  always_comb begin
    phase_d = phase_q;
    idx_d   = digit_idx;
    val_d   = val_q;
    dps_d   = dps_q;
    en_d    = en_q;
    anode_d = anode_out;
    seg_d   = seg_out;
    dp_d    = dp_out;
    if (tick) begin
      idx_d = wrap ? '0 : digit_idx + 1'b1;
      if (wrap) begin
        val_d = value_in;
        dps_d = dp_in;
`ifdef LEADING_ZERO_BLANK_EN
        en_d  = lz_mask(value_in, dp_in, digit_en);
`else
        en_d  = digit_en;
`endif
      end
      seg_d   = hex7(nibble_at(val_d, idx_d)) ^ SEG_OFF;
      dp_d    = dps_d[idx_d] ^ ACTIVE_LOW;
      anode_d = AN_OFF;
      phase_d = BLANK;
    end else if (phase_q == BLANK) begin
      anode_d = (sel & en_q) ^ AN_OFF;
      phase_d = IDLE;
    end
  end

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= refresh_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      phase_q   <= IDLE;
      digit_idx <= IDX_TOP;
      val_q     <= '0;
      dps_q     <= '0;
      en_q      <= '0;
      anode_out <= AN_OFF;
      seg_out   <= SEG_OFF;
      dp_out    <= ACTIVE_LOW;
    end else begin
      phase_q   <= phase_d;
      digit_idx <= idx_d;
      val_q     <= val_d;
      dps_q     <= dps_d;
      en_q      <= en_d;
      anode_out <= anode_d;
      seg_out   <= seg_d;
      dp_out    <= dp_d;
    end
  end

endmodule
